// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: credit-limited request/grant fetch into an in-order
// {PC, IR} queue, with branch redirect that squashes queued and in-flight work.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          QDEPTH          = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_take_branch_out,
   input  logic [31:0] ex_target_PC_out,
   output logic        proc2Imem_req,
   output logic [31:0] proc2Imem_addr,
   input  logic        Imem2proc_gnt,
   input  logic        Imem2proc_valid,
   input  logic [31:0] Imem2proc_data,
   input  logic        id_ready,
   output logic        if_valid_inst_out,
   output logic [31:0] if_PC_out,
   output logic [31:0] if_NPC_out,
   output logic [31:0] if_IR_out,
   output logic        if_err_out
);

   localparam int QAW = $clog2(QDEPTH);
   localparam int CW  = $clog2(QDEPTH + 1);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int FAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   logic [31:0]    fetch_pc;
   logic [OW-1:0]  outstanding;
   logic [OW-1:0]  drop;
   logic [OW-1:0]  live;
   logic [FAW-1:0] fl_wr;
   logic [FAW-1:0] fl_rd;
   logic [31:0]    fl_pc [MAX_OUTSTANDING];
   logic [QAW-1:0] q_head;
   logic [QAW-1:0] q_tail;
   logic [CW-1:0]  count;
   logic [31:0]    q_pc [QDEPTH];
   logic [31:0]    q_ir [QDEPTH];
   logic           err;
   logic [31:0]    occ;
   logic           accept;
   logic           resp;
   logic           keep;
   logic           pop;

   function automatic logic [FAW-1:0] fl_inc(input logic [FAW-1:0] p);
      return (32'(p) == 32'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   // Credit counts queued entries plus live in-flight ones, so the queue can never overflow.
   assign live   = outstanding - drop;
   assign occ    = 32'(count) + 32'(live);
   assign proc2Imem_req  = rst_n & ~ex_take_branch_out
                         & (32'(outstanding) < 32'(MAX_OUTSTANDING))
                         & (occ < 32'(QDEPTH));
   assign proc2Imem_addr = fetch_pc;

   assign accept = proc2Imem_req & Imem2proc_gnt;
   assign resp   = Imem2proc_valid & (outstanding != '0);
   assign keep   = resp & (drop == '0) & ~ex_take_branch_out;
   assign pop    = (count != '0) & id_ready & ~ex_take_branch_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC & ~32'h3;
         outstanding <= '0;
         drop        <= '0;
         fl_wr       <= '0;
         fl_rd       <= '0;
         q_head      <= '0;
         q_tail      <= '0;
         count       <= '0;
         err         <= 1'b0;
      end else begin
         if (ex_take_branch_out)
            fetch_pc <= ex_target_PC_out & ~32'h3;
         else if (accept)
            fetch_pc <= fetch_pc + 32'd4;

         outstanding <= outstanding + OW'(accept) - OW'(resp);

         // Everything still in flight after this cycle belongs to the old path.
         if (ex_take_branch_out)
            drop <= outstanding - OW'(resp);
         else if (resp && (drop != '0))
            drop <= drop - 1'b1;

         if (accept) fl_wr <= fl_inc(fl_wr);
         if (resp)   fl_rd <= fl_inc(fl_rd);

         if (ex_take_branch_out) begin
            q_head <= q_tail;
            count  <= '0;
         end else begin
            if (pop)  q_head <= q_head + 1'b1;
            if (keep) q_tail <= q_tail + 1'b1;
            count <= count + CW'(keep) - CW'(pop);
         end

         if (Imem2proc_valid && (outstanding == '0))
            err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         fl_pc[fl_wr] <= fetch_pc;
      if (keep) begin
         q_pc[q_tail] <= fl_pc[fl_rd];
         q_ir[q_tail] <= Imem2proc_data;
      end
   end

   // Head fields read as zero when empty so reset values need no data reset.
   assign if_valid_inst_out = (count != '0);
   assign if_PC_out         = if_valid_inst_out ? q_pc[q_head] : 32'h0;
   assign if_IR_out         = if_valid_inst_out ? q_ir[q_head] : 32'h0;
   assign if_NPC_out        = if_PC_out + 32'd4;
   assign if_err_out        = err;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling instruction queue. It issues word-aligned fetch requests to instruction memory over a request/grant handshake and accepts in-order responses with arbitrary latency. It buffers fetched instructions and hands them to decode under valid/ready backpressure. On a taken branch it redirects and flushes, discarding any responses still in flight from the old path.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] ignored.
- QDEPTH, 4, instruction queue entries; power of 2, ≥2.
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; ≥1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_take_branch_out  in  1  redirect request from EX.
- ex_target_PC_out  in  32  redirect target; bits [1:0] forced to 0.
- proc2Imem_req  out  1  fetch request valid.
- proc2Imem_addr  out  32  fetch address, always word-aligned.
- Imem2proc_gnt  in  1  memory accepts the request this cycle.
- Imem2proc_valid  in  1  response valid; responses return in request order.
- Imem2proc_data  in  32  response instruction.
- id_ready  in  1  decode accepts the head instruction this cycle.
- if_valid_inst_out  out  1  head entry valid.
- if_PC_out  out  32  PC of the head instruction.
- if_NPC_out  out  32  if_PC_out + 4, modulo 2^32.
- if_IR_out  out  32  head instruction.
- if_err_out  out  1  sticky flag for a response received with nothing outstanding.

## Operation
- State:
  - fetch_PC.
  - outstanding counter, 0..MAX_OUTSTANDING.
  - drop counter, 0..MAX_OUTSTANDING.
  - in-flight PC FIFO, depth MAX_OUTSTANDING.
  - {PC, IR} queue, depth QDEPTH, with count.
- Live in-flight = outstanding − drop.
- proc2Imem_req = rst_n & !ex_take_branch_out & (outstanding < MAX_OUTSTANDING) & (count + live < QDEPTH).
- This credit rule means the queue can never overflow. No credit is taken from a same-cycle pop.
- proc2Imem_addr = fetch_PC.
- Accept: when req & gnt, push fetch_PC to the in-flight FIFO, set fetch_PC += 4 (wraps), and outstanding++.
- Response: when Imem2proc_valid & outstanding > 0, pop the in-flight FIFO and decrement outstanding.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise: push {popped PC, data} to the queue.
- Response while outstanding == 0: ignore it and set if_err_out. It clears only on reset.
- Output: if_valid_inst_out = (count != 0). If_PC_out/if_IR_out show the head entry. A pop occurs when valid & id_ready.
- Redirect: when ex_take_branch_out = 1, at the next edge:
  - fetch_PC ← target & ~3.
  - Queue count ← 0; that cycle's pop and push are both suppressed.
  - drop ← outstanding after this cycle's response is counted. The same-cycle response is itself discarded.
  - No request is issued in the redirect cycle.
- The head stays visible during the redirect cycle; EX flush logic squashes it downstream.
- Simultaneous accept + response + pop in one cycle is legal. Counters update by net change.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - fetch_PC = RESET_PC & ~3.
  - outstanding = drop = count = 0.
  - proc2Imem_req = 0.
  - if_valid_inst_out = 0, if_PC_out = 0, if_IR_out = 0, if_NPC_out = 4.
  - if_err_out = 0.
- First request: proc2Imem_req rises combinationally in the first cycle after rst_n is released.
- Fetch latency: granted in cycle t, response in cycle t+k (k ≥ 1), head visible in cycle t+k+1 if the queue was empty.
- No same-cycle bypass from Imem2proc_data to if_IR_out.
- While req & !gnt, proc2Imem_addr holds stable unless a redirect occurs. The address then changes and req drops for that cycle.
- With zero-wait memory (gnt = 1, response next cycle) and id_ready = 1, throughput is 1 instruction/cycle when MAX_OUTSTANDING ≥ 2.
- First instruction after redirect: the request is issued in the cycle after the redirect, and is visible ≥2 cycles later.
- Reset asserted mid-transaction drops all in-flight state immediately. Late memory responses arriving after reset set if_err_out.

## Test plan
- Reset with RESET_PC = 32'h100, gnt = 1, 1-cycle response, id_ready = 1:
  - addr sequence 0x100, 0x104, 0x108…
  - if_PC_out 0x100 first visible in cycle 2, then one instruction per cycle, with NPC = PC + 4.
- id_ready = 0 for 10 cycles with default parameters:
  - req deasserts once count + live = 4.
  - Queue holds 0x0..0xC in order.
  - No response is lost when id_ready reasserts.
- Redirect to 0x2001 while 2 requests are outstanding and 3-cycle memory latency:
  - next addr = 0x2000.
  - Both old responses are discarded.
  - First valid head is PC 0x2000.
- Redirect in the same cycle as a response and a pop:
  - Response discarded, queue empty next cycle, drop = remaining outstanding.
- gnt held 0 for 5 cycles with req high:
  - addr stable throughout; fetch_PC advances only on the grant cycle.
- Imem2proc_valid pulse with no outstanding request:
  - if_err_out = 1 and stays set.
  - Queue unchanged; err cleared only by rst_n low.
- fetch_PC = 32'hFFFF_FFFC:
  - next addr 0x0000_0000.
  - if_NPC_out for that head = 0x0000_0000.
